// File: rtl/pulse_scheduler_pkg.sv
// Shared types and constants for the pulse scheduler: FSM encoding, the gap length and
// the owner-index width helper.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam int GAP_CYCLES = 1;

  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_scheduler_if.sv
// Request/length inputs and pulse/status outputs of the pulse scheduler, bundled so the
// producer side (master) and the scheduler (slave) share one definition.
interface pulse_scheduler_if
  import pulse_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int PULSE_SIZE = 16
);

  localparam int OWN_W = owner_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*PULSE_SIZE-1:0] len;
  logic                          pulse_out;
  logic [OWN_W-1:0]              owner;
  logic                          busy;
  logic                          done;
  logic [NUM_REQ-1:0]            pending;

  modport master (
    output req, len,
    input  pulse_out, owner, busy, done, pending
  );

  modport slave (
    input  req, len,
    output pulse_out, owner, busy, done, pending
  );

endinterface

// File: rtl/pulse_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the first pending channel found scanning upward from
// the one after the most recent grant, wrapping at NUM_REQ.
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int OWN_W   = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_pending,
  input  logic [OWN_W-1:0]   i_last_grant,
  output logic               o_grant_valid,
  output logic [OWN_W-1:0]   o_grant_idx
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;

  // Rotate so bit 0 is the channel right after the last grant.
  assign w_dbl = {i_pending, i_pending} >> (int'(i_last_grant) + 1);
  assign w_rot = w_dbl[NUM_REQ-1:0];

  // Lowest set bit of the rotated vector wins; map it back to a channel index.
  always_comb begin
    o_grant_valid = |w_rot;
    o_grant_idx   = {OWN_W{1'b0}};
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      o_grant_idx = w_rot[j] ? OWN_W'((int'(i_last_grant) + 1 + j) % NUM_REQ) : o_grant_idx;
    end
  end

endmodule

// File: rtl/pulse_scheduler.sv
// Shares one pulse-stretching timer among NUM_REQ strobe sources: latches requests,
// grants round-robin, emits one high pulse of the granted length and a fixed low gap.
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int PULSE_SIZE = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  pulse_scheduler_if.slave  bus
);

  localparam int                    OWN_W    = owner_w(NUM_REQ);
  localparam logic [OWN_W-1:0]      LAST_RST = OWN_W'(NUM_REQ - 1);
  localparam logic [PULSE_SIZE-1:0] CNT_ONE  = PULSE_SIZE'(1);
  localparam logic [PULSE_SIZE-1:0] CNT_GAP  = PULSE_SIZE'(GAP_CYCLES);
  localparam logic [PULSE_SIZE-1:0] CNT_ZERO = {PULSE_SIZE{1'b0}};

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [PULSE_SIZE-1:0]  r_counter;
  logic [PULSE_SIZE-1:0]  w_counter_nx;
  logic [PULSE_SIZE-1:0]  w_len_sel;
  logic [NUM_REQ-1:0]     r_pending;
  logic [NUM_REQ-1:0]     w_clear;
  logic [OWN_W-1:0]       r_owner;
  logic [OWN_W-1:0]       r_last_grant;
  logic [OWN_W-1:0]       w_grant_idx;
  logic                   w_grant_valid;
  logic                   w_grant;
  logic                   r_pulse;
  logic                   r_busy;
  logic                   r_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_pending     (r_pending),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  assign w_len_sel = bus.len[int'(w_grant_idx)*PULSE_SIZE +: PULSE_SIZE];
  assign w_clear   = w_grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant_idx) : {NUM_REQ{1'b0}};

  // Next-state and counter: the counter times the pulse in ACTIVE, then the gap in GAP.
  always_comb begin
    w_state_nx   = r_state;
    w_counter_nx = r_counter;
    w_grant      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_state_nx   = ST_ACTIVE;
          w_counter_nx = (w_len_sel == CNT_ZERO) ? CNT_ONE : w_len_sel;
          w_grant      = 1'b1;
        end else begin
          w_state_nx   = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (r_counter <= CNT_ONE) begin
          w_state_nx   = ST_GAP;
          w_counter_nx = CNT_GAP;
        end else begin
          w_counter_nx = r_counter - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (r_counter <= CNT_ONE) begin
          w_state_nx   = ST_IDLE;
          w_counter_nx = CNT_ZERO;
        end else begin
          w_counter_nx = r_counter - CNT_ONE;
        end
      end
      default: begin
        w_state_nx   = ST_IDLE;
        w_counter_nx = CNT_ZERO;
      end
    endcase
  end

  // State, pending latch (new strobes beat the grant clear) and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_counter    <= CNT_ZERO;
      r_pending    <= {NUM_REQ{1'b0}};
      r_owner      <= {OWN_W{1'b0}};
      r_last_grant <= LAST_RST;
      r_pulse      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_counter <= w_counter_nx;
      r_pending <= (r_pending & ~w_clear) | bus.req;
      r_pulse   <= (w_state_nx == ST_ACTIVE);
      r_busy    <= (w_state_nx != ST_IDLE);
      r_done    <= (w_state_nx == ST_ACTIVE) && (w_counter_nx == CNT_ONE);
      if (w_grant) begin
        r_owner      <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end
    end
  end

  assign bus.pulse_out = r_pulse;
  assign bus.owner     = r_owner;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pending   = r_pending;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Self-checking bench for pulse_scheduler: directed scenarios plus a randomized run
// compared against a timeline-based reference model.
module tb_pulse_scheduler;
  import pulse_sched_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pulse_scheduler_if #(.NUM_REQ(N), .PULSE_SIZE(W)) bus ();

  pulse_scheduler #(.NUM_REQ(N), .PULSE_SIZE(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a grant at edge g with length L makes the pulse high after edges
  // g..g+L-1, busy through g+L, and the next grant possible at edge g+L+2.
  logic [W-1:0] lens [N];
  logic [N-1:0] m_pend;
  int cyc = 0;
  int m_last, m_owner, m_start, m_end, m_free;
  int m_grants = 0;

  function automatic logic exp_pulse();
    return (cyc >= m_start) && (cyc <= m_end);
  endfunction

  function automatic logic exp_busy();
    return (cyc >= m_start) && (cyc <= m_end + 1);
  endfunction

  function automatic logic exp_done();
    return (cyc == m_end);
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_last  = N - 1;
    m_owner = 0;
    m_start = -10;
    m_end   = -10;
    m_free  = cyc;
  endtask

  task automatic tick();
    logic [N-1:0] r;
    int w, l;
    r = bus.req;
    @(posedge clk);
    cyc++;
    if (cyc >= m_free && m_pend != '0) begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        if (w < 0 && m_pend[(m_last + k) % N]) w = (m_last + k) % N;
      end
      l = (lens[w] == '0) ? 1 : int'(lens[w]);
      m_start = cyc;
      m_end   = cyc + l - 1;
      m_free  = cyc + l + 2;
      m_pend[w] = 1'b0;
      m_owner = w;
      m_last  = w;
      m_grants++;
    end
    m_pend = m_pend | r;
    @(negedge clk);
  endtask

  task automatic set_len(input int ch, input logic [W-1:0] v);
    lens[ch] = v;
    bus.len[ch*W +: W] = v;
  endtask

  task automatic strobe(input logic [N-1:0] m);
    bus.req = m;
    tick();
    bus.req = '0;
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req = '0;
    for (int i = 0; i < N; i++) set_len(i, 16'd0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.pulse_out !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", bus.pulse_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", bus.owner); end
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", bus.pending); end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int hi, first_hi, done_at, busy_fall;
    set_len(0, 16'd5);
    strobe(4'b0001);
    checks++; if (bus.pending !== 4'b0001) begin errors++; $display("FAIL single_pending: got %b expected 0001", bus.pending); end
    checks++; if (bus.pulse_out !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", bus.pulse_out); end
    hi = 0; first_hi = -1; done_at = -1; busy_fall = -1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (bus.pulse_out === 1'b1) begin
        hi++;
        if (first_hi < 0) first_hi = t;
      end
      if (bus.done === 1'b1) done_at = t;
      if (bus.busy !== 1'b1 && busy_fall < 0 && hi > 0) busy_fall = t;
    end
    checks++; if (first_hi != 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", first_hi); end
    checks++; if (hi != 5) begin errors++; $display("FAIL single_width: got %0d expected 5", hi); end
    checks++; if (done_at != 5) begin errors++; $display("FAIL single_done: got %0d expected 5", done_at); end
    checks++; if (busy_fall != 7) begin errors++; $display("FAIL single_busy_fall: got %0d expected 7", busy_fall); end
    checks++; if (bus.owner !== 2'd0) begin errors++; $display("FAIL single_owner: got %0d expected 0", bus.owner); end
  endtask

  task automatic test_all_four();
    int own [4];
    logic [3:0] pnd [4];
    int hrun [4];
    int lrun [4];
    int g, run;
    logic prev;
    logic [3:0] ep;
    do_reset();
    for (int i = 0; i < N; i++) set_len(i, 16'd3);
    for (int i = 0; i < 4; i++) begin own[i] = -1; pnd[i] = 'x; hrun[i] = -1; lrun[i] = -1; end
    strobe(4'b1111);
    checks++; if (bus.pending !== 4'b1111) begin errors++; $display("FAIL all_pending0: got %b expected 1111", bus.pending); end
    prev = 1'b0; g = 0; run = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (bus.pulse_out === 1'b1 && prev == 1'b0) begin
        if (g < 4) begin own[g] = int'(bus.owner); pnd[g] = bus.pending; lrun[g] = run; end
        run = 0;
        g++;
      end else if (bus.pulse_out !== prev) begin
        if (g >= 1 && g <= 4) hrun[g-1] = run;
        run = 0;
      end
      run++;
      prev = bus.pulse_out;
    end
    checks++; if (g != 4) begin errors++; $display("FAIL all_count: got %0d expected 4", g); end
    for (int k = 0; k < 4; k++) begin
      ep = 4'b1111 << (k + 1);
      checks++; if (own[k] != k) begin errors++; $display("FAIL all_owner%0d: got %0d expected %0d", k, own[k], k); end
      checks++; if (pnd[k] !== ep) begin errors++; $display("FAIL all_pending%0d: got %b expected %b", k, pnd[k], ep); end
      checks++; if (hrun[k] != 3) begin errors++; $display("FAIL all_high%0d: got %0d expected 3", k, hrun[k]); end
      if (k > 0) begin
        checks++; if (lrun[k] != 2) begin errors++; $display("FAIL all_low%0d: got %0d expected 2", k, lrun[k]); end
      end
    end
  endtask

  task automatic test_fairness();
    int seq [3];
    int g, g0;
    logic prev;
    do_reset();
    for (int i = 0; i < N; i++) set_len(i, 16'd2);
    for (int i = 0; i < 3; i++) seq[i] = -1;
    g = 0; g0 = m_grants; prev = 1'b0;
    for (int t = 0; t < 30; t++) begin
      bus.req = {1'b0, (t == 1) ? 1'b1 : 1'b0, 1'b0, (t < 12) ? 1'b1 : 1'b0};
      tick();
      if (bus.pulse_out === 1'b1 && prev == 1'b0) begin
        if (g < 3) seq[g] = int'(bus.owner);
        g++;
      end
      prev = bus.pulse_out;
    end
    bus.req = '0;
    checks++; if (seq[0] != 0 || seq[1] != 2 || seq[2] != 0) begin errors++; $display("FAIL fair_order: got %0d,%0d,%0d expected 0,2,0", seq[0], seq[1], seq[2]); end
    checks++; if (g != m_grants - g0) begin errors++; $display("FAIL fair_merge: got %0d grants expected %0d", g, m_grants - g0); end
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL fair_drain: got %b expected 0000", bus.pending); end
  endtask

  task automatic test_boundary();
    int hi, dn, rises, done_t, last_hi, t;
    logic prev;
    set_len(1, 16'd0);
    strobe(4'b0010);
    hi = 0; dn = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.pulse_out === 1'b1) hi++;
      if (bus.done === 1'b1) dn++;
    end
    checks++; if (hi != 1) begin errors++; $display("FAIL len0_width: got %0d expected 1", hi); end
    checks++; if (dn != 1) begin errors++; $display("FAIL len0_done: got %0d expected 1", dn); end
    set_len(3, 16'hFFFF);
    strobe(4'b1000);
    hi = 0; dn = 0; rises = 0; done_t = -1; last_hi = -2; t = 0; prev = 1'b0;
    while (t < 70000 && !(hi > 0 && bus.busy !== 1'b1)) begin
      tick();
      t++;
      if (bus.pulse_out === 1'b1) begin hi++; last_hi = t; end
      if (bus.pulse_out === 1'b1 && prev == 1'b0) rises++;
      if (bus.done === 1'b1) begin dn++; done_t = t; end
      prev = bus.pulse_out;
    end
    checks++; if (t >= 70000) begin errors++; $display("FAIL lenmax_timeout: got %0d cycles expected under 70000", t); end
    checks++; if (hi != 65535) begin errors++; $display("FAIL lenmax_width: got %0d expected 65535", hi); end
    checks++; if (rises != 1) begin errors++; $display("FAIL lenmax_rises: got %0d expected 1", rises); end
    checks++; if (dn != 1 || done_t != last_hi) begin errors++; $display("FAIL lenmax_done: got count %0d at %0d expected 1 at %0d", dn, done_t, last_hi); end
  endtask

  task automatic test_reenter();
    int rises, bad_owner, run, gaps_bad;
    logic prev;
    set_len(2, 16'd4);
    strobe(4'b0100);
    rises = 0; bad_owner = 0; run = 0; gaps_bad = 0; prev = 1'b0;
    for (int t = 1; t <= 24; t++) begin
      bus.req = (t == 1 || t == 8) ? 4'b0100 : 4'b0000;
      tick();
      if (t == 1) begin
        checks++; if (bus.pending !== 4'b0100) begin errors++; $display("FAIL reenter_same_edge: got %b expected 0100", bus.pending); end
      end
      if (bus.pulse_out === 1'b1 && prev == 1'b0) begin
        rises++;
        if (bus.owner !== 2'd2) bad_owner++;
        if (rises > 1 && run != 2) gaps_bad++;
        run = 0;
      end else if (bus.pulse_out !== prev) begin
        run = 0;
      end
      run++;
      prev = bus.pulse_out;
    end
    bus.req = '0;
    checks++; if (rises != 3) begin errors++; $display("FAIL reenter_count: got %0d expected 3", rises); end
    checks++; if (bad_owner != 0) begin errors++; $display("FAIL reenter_owner: got %0d wrong owners expected 0", bad_owner); end
    checks++; if (gaps_bad != 0) begin errors++; $display("FAIL reenter_gap: got %0d bad gaps expected 0", gaps_bad); end
  endtask

  task automatic test_reset_mid();
    int second;
    logic prev;
    do_reset();
    for (int i = 0; i < N; i++) set_len(i, 16'd10);
    strobe(4'b0010);
    tick();
    strobe(4'b1010);
    tick();
    checks++; if (bus.pending !== 4'b1010 || bus.pulse_out !== 1'b1) begin errors++; $display("FAIL midrst_setup: got pend %b pulse %b expected 1010 1", bus.pending, bus.pulse_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.pulse_out !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_async: got pulse %b busy %b expected 0 0", bus.pulse_out, bus.busy); end
    checks++; if (bus.pending !== 4'b0000 || bus.owner !== 2'd0) begin errors++; $display("FAIL midrst_clear: got pend %b owner %0d expected 0000 0", bus.pending, bus.owner); end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    strobe(4'b1001);
    tick();
    checks++; if (bus.owner !== 2'd0 || bus.pulse_out !== 1'b1) begin errors++; $display("FAIL midrst_first: got owner %0d pulse %b expected 0 1", bus.owner, bus.pulse_out); end
    second = -1; prev = 1'b1;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (bus.pulse_out === 1'b1 && prev == 1'b0 && second < 0) second = int'(bus.owner);
      prev = bus.pulse_out;
    end
    checks++; if (second != 3) begin errors++; $display("FAIL midrst_second: got %0d expected 3", second); end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 7) == 0);
      bus.req = r;
      if ($urandom_range(0, 15) == 0) set_len(int'($urandom_range(0, N - 1)), W'($urandom_range(0, 6)));
      tick();
      checks++; if (bus.pulse_out !== exp_pulse()) begin errors++; if (errors < 30) $display("FAIL rnd_pulse@%0d: got %b expected %b", cyc, bus.pulse_out, exp_pulse()); end
      checks++; if (bus.busy !== exp_busy()) begin errors++; if (errors < 30) $display("FAIL rnd_busy@%0d: got %b expected %b", cyc, bus.busy, exp_busy()); end
      checks++; if (bus.done !== exp_done()) begin errors++; if (errors < 30) $display("FAIL rnd_done@%0d: got %b expected %b", cyc, bus.done, exp_done()); end
      checks++; if (bus.owner !== 2'(m_owner)) begin errors++; if (errors < 30) $display("FAIL rnd_owner@%0d: got %0d expected %0d", cyc, bus.owner, m_owner); end
      checks++; if (bus.pending !== m_pend) begin errors++; if (errors < 30) $display("FAIL rnd_pending@%0d: got %b expected %b", cyc, bus.pending, m_pend); end
    end
    bus.req = '0;
  endtask

  initial begin
    bus.req = '0;
    bus.len = '0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_boundary();
    test_reenter();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
